muldiv_seq: RTL and testbench

Multi-cycle multiply/divide sequencer for the single-clock CPU's HI/LO unit. It executes MIPS-style MULT, MULTU, DIV and DIVU by time-multiplexing one adder32 instance over 32 iteration cycles, using shift-add for multiply and restoring division for divide. The execute stage issues a one-cycle start and then stalls on busy until done.

---
 rtl/muldiv_seq_pkg.sv | 36 +++
 rtl/muldiv_seq_if.sv | 34 +++
 rtl/muldiv_seq_adder32.sv | 30 +++
 rtl/muldiv_seq.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_seq_pkg.sv
// ============================================================================
//  Module   : muldiv_seq_pkg
//  Purpose  : Shared op codes, FSM states and iteration constants for the
//             multi-cycle multiply/divide sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_seq_pkg;

    localparam int DATA_W  = 32;
    localparam int MD_ITER = 32;
    localparam int CNT_W   = $clog2(MD_ITER);

    typedef logic [1:0] op_t;

    localparam op_t OP_MULTU = 2'b00;
    localparam op_t OP_MULT  = 2'b01;
    localparam op_t OP_DIVU  = 2'b10;
    localparam op_t OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                   input logic              en);
        return en ? (~v + 1'b1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_seq_if.sv
// ============================================================================
//  Module   : muldiv_seq_if
//  Purpose  : Request/result bundle between the execute stage and the
//             multiply/divide sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_seq_if;
    import muldiv_seq_pkg::*;

    logic              start;
    op_t               op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              div_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_zero
    );

endinterface

`default_nettype wire

// File: rtl/muldiv_seq_adder32.sv
// ============================================================================
//  Module   : muldiv_seq_adder32
//  Purpose  : 32-bit add/subtract unit (mode=1 inverts b) with carry and
//             signed-overflow flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq_adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    input  logic        mode,
    output logic [31:0] s,
    output logic        cf,
    output logic        of
);

    logic [31:0] w_b_eff;
    logic [32:0] w_total;

    assign w_b_eff = mode ? ~b : b;
    assign w_total = {1'b0, a} + {1'b0, w_b_eff} + {32'b0, cin};
    assign s       = w_total[31:0];
    assign cf      = w_total[32];
    assign of      = (a[31] == w_b_eff[31]) && (s[31] != a[31]);

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
//  Module   : muldiv_seq
//  Purpose  : MULT/MULTU/DIV/DIVU sequencer: 32 shift-add or restoring-divide
//             steps on one shared adder, then sign fix-up and result write.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int ITER  = MD_ITER
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_seq_if.slave bus
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    op_t                r_op;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi_out;
    logic [WIDTH-1:0]   r_lo_out;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;

    logic               w_b_zero;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_div_p;
    logic               w_div_take;
    logic [WIDTH-1:0]   w_add_a;
    logic [WIDTH-1:0]   w_add_b;
    logic               w_add_cin;
    logic               w_add_mode;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cf;
    logic               w_of;
    logic               w_unused;

    assign w_b_zero = (bus.b == '0);
    assign w_a_mag  = cond_neg(bus.a, bus.op[0] & bus.a[WIDTH-1]);
    assign w_b_mag  = cond_neg(bus.b, bus.op[0] & bus.b[WIDTH-1]);

    // Divide step: remainder shifted left, pulling in the next dividend bit.
    assign w_div_p    = {r_acc[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_div_take = r_acc[WIDTH-1] | w_cf;

    always_comb begin
        w_add_a    = r_acc;
        w_add_b    = r_lo[0] ? r_mcand : '0;
        w_add_cin  = 1'b0;
        w_add_mode = 1'b0;
        if (r_op[1]) begin
            w_add_a    = w_div_p;
            w_add_b    = r_mcand;
            w_add_cin  = 1'b1;
            w_add_mode = 1'b1;
        end
    end

    muldiv_seq_adder32 u_adder32 (
        .a    (w_add_a),
        .b    (w_add_b),
        .cin  (w_add_cin),
        .mode (w_add_mode),
        .s    (w_sum),
        .cf   (w_cf),
        .of   (w_of)
    );

    assign w_unused = w_of;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.op[1] && w_b_zero) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == CNT_W'(ITER - 1)) begin
                    w_next = ST_FIX;
                end
            end
            ST_FIX:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_dz       <= 1'b0;
            r_mcand    <= '0;
            r_acc      <= '0;
            r_lo       <= '0;
            r_hi_out   <= '0;
            r_lo_out   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_op       <= bus.op;
                        r_sign_q   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        r_sign_r   <= bus.a[WIDTH-1];
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_div_zero <= 1'b0;
                        r_dz       <= 1'b0;
                        if (bus.op[1]) begin
                            r_mcand <= w_b_mag;
                            if (w_b_zero) begin
                                r_acc <= bus.a;
                                r_lo  <= '1;
                                r_dz  <= 1'b1;
                            end else begin
                                r_acc <= '0;
                                r_lo  <= w_a_mag;
                            end
                        end else begin
                            r_mcand <= w_a_mag;
                            r_acc   <= '0;
                            r_lo    <= w_b_mag;
                        end
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_op[1]) begin
                        if (w_div_take) begin
                            r_acc <= w_sum;
                            r_lo  <= {r_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc <= w_div_p;
                            r_lo  <= {r_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_acc <= {w_cf, w_sum[WIDTH-1:1]};
                        r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
                    end
                end
                ST_FIX: begin
                    if (r_op[1]) begin
                        r_lo  <= cond_neg(r_lo,  r_op[0] & r_sign_q);
                        r_acc <= cond_neg(r_acc, r_op[0] & r_sign_r);
                    end else if (r_op[0] && r_sign_q) begin
                        {r_acc, r_lo} <= -{r_acc, r_lo};
                    end
                end
                ST_DONE: begin
                    // Results become visible together with done so hi/lo never move while busy.
                    r_hi_out   <= r_acc;
                    r_lo_out   <= r_lo;
                    r_div_zero <= r_dz;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.hi       = r_hi_out;
    assign bus.lo       = r_lo_out;
    assign bus.div_zero = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ============================================================================
//  Module   : tb_muldiv_seq
//  Purpose  : Self-checking bench for muldiv_seq (vector table, corner
//             sequences and randomized ops against an arithmetic model).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_seq_if bus ();

    muldiv_seq #(.WIDTH(32), .ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        dz = 1'b0;
        if (op[1] && b == 32'd0) begin
            hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
        end else begin
            case (op)
                OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
                OP_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
                OP_DIVU:  begin lo = a / b; hi = a % b; end
                default:  begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            endcase
        end
    endfunction

    // One complete operation; pulse_at >= 0 injects a stray start after that many busy cycles.
    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                       input int elat, input int pulse_at, input string tag);
        int n;
        int busy_bad;
        int moved;
        logic done_seen;
        logic [31:0] hold_hi, hold_lo;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        hold_hi = bus.hi; hold_lo = bus.lo;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
        chk({tag, "_busy_after_start"}, 64'(bus.busy), 64'd1);
        chk({tag, "_div_zero_cleared"}, 64'(bus.div_zero), 64'd0);
        n = 0; busy_bad = 0; moved = 0; done_seen = 1'b0;
        while (!done_seen && n < 60) begin
            if (n == pulse_at) begin
                bus.start = 1'b1; bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            n++;
            if (bus.done) done_seen = 1'b1;
            else begin
                if (!bus.busy) busy_bad++;
                if (bus.hi !== hold_hi || bus.lo !== hold_lo) moved++;
            end
        end
        chk({tag, "_latency"},   64'(n), 64'(elat));
        chk({tag, "_hi"},        64'(bus.hi), 64'(ehi));
        chk({tag, "_lo"},        64'(bus.lo), 64'(elo));
        chk({tag, "_div_zero"},  64'(bus.div_zero), 64'(edz));
        chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({tag, "_busy_gaps"}, 64'(busy_bad), 64'd0);
        chk({tag, "_hilo_held"}, 64'(moved), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_single"}, 64'(bus.done), 64'd0);
        chk({tag, "_idle_after"},  64'(bus.busy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb, rhi, rlo;
        logic        rdz;

        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;

        tbl[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 34};
        tbl[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34};
        tbl[2]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0, 34};
        tbl[3]  = '{OP_DIVU,  32'd100,       32'd7,          32'd2,         32'd14,        1'b0, 34};
        tbl[4]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
        tbl[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0, 34};
        tbl[6]  = '{OP_DIVU,  32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF, 1'b1, 1};
        tbl[7]  = '{OP_MULTU, 32'd3,         32'd4,          32'd0,         32'd12,        1'b0, 34};
        tbl[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 1'b0, 34};
        tbl[9]  = '{OP_DIV,   32'h8000_0000, 32'd0,          32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1};
        tbl[10] = '{OP_MULTU, 32'd0,         32'hDEAD_BEEF,  32'd0,         32'd0,         1'b0, 34};

        #12;
        chk("reset_busy",     64'(bus.busy), 64'd0);
        chk("reset_done",     64'(bus.done), 64'd0);
        chk("reset_hi",       64'(bus.hi), 64'd0);
        chk("reset_lo",       64'(bus.lo), 64'd0);
        chk("reset_div_zero", 64'(bus.div_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dz,
                tbl[i].lat, -1, $sformatf("vec%0d", i));
        end

        // Stray starts mid-CALC, in DONE and in the div-by-zero DONE cycle are dropped.
        run(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34, 10, "ign_calc");
        run(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 33, "ign_done");
        run(OP_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1, 1, 0, "ign_dz");
        run(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34, -1, "pre_reset");

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (16) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy",     64'(bus.busy), 64'd0);
        chk("async_rst_done",     64'(bus.done), 64'd0);
        chk("async_rst_hi",       64'(bus.hi), 64'd0);
        chk("async_rst_lo",       64'(bus.lo), 64'd0);
        chk("async_rst_div_zero", 64'(bus.div_zero), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 34, -1, "after_reset");

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
            if ($urandom_range(0, 7) == 0)      rb = 32'd0;
            else if ($urandom_range(0, 1) == 1) rb = 32'($urandom_range(1, 20));
            else                                rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = -rb;
            model(rop, ra, rb, rhi, rlo, rdz);
            run(rop, ra, rb, rhi, rlo, rdz, rdz ? 1 : 34, -1, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
